regfile_access_arb: RTL and testbench

Owns the core's 32x64 general-purpose register file and arbitrates its single write port between the pipeline writeback stage and the debug/difftest restore port. Provides two combinational read ports to decode and runs a snapshot-dump engine that streams all 32 GPRs, one per beat, to the difftest checker after a commit. Sits beside the DPI-C GPR mirror; the dump stream is the checker's authoritative register image.

---
 rtl/regfile_access_arb.sv | 115 +++++++++++
 tb/tb_regfile_access_arb.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arb.sv
// 32x64 GPR file with arbitrated write port, two read ports and a
// snapshot-dump engine streaming every GPR to the difftest checker.
module regfile_access_arb #(
  parameter int XLEN       = 64,
  parameter int NREG       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            dump_req,
  output logic            dump_busy,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last
);

  localparam int SW0 = $clog2(STARVE_MAX + 1);
  localparam int SW  = (SW0 > 3) ? SW0 : 3;

  typedef enum logic {
    IDLE,
    DUMP
  } state_t;

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [XLEN-1:0] rf [NREG-1:1];

  logic            is_idle;
  logic            force_dbg;
  logic            wb_fire;
  logic            dbg_fire;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            at_max;

  assign is_idle   = (state == IDLE) && !rst;
  assign at_max    = (starve_cnt == SW'(STARVE_MAX));
  assign force_dbg = at_max && dbg_valid;

  assign wb_ready  = is_idle && !force_dbg;
  assign dbg_ready = is_idle && (!wb_valid || force_dbg);

  assign wb_fire   = wb_valid && wb_ready;
  assign dbg_fire  = dbg_valid && dbg_ready;

  // The two readies are exclusive whenever both requesters are valid.
  assign wr_en     = wb_fire || dbg_fire;
  assign wr_addr   = wb_fire ? wb_addr : dbg_addr;
  assign wr_data   = wb_fire ? wb_data : dbg_data;

  assign rs1_data  = (rs1_addr == 5'd0) ? '0 : rf[rs1_addr];
  assign rs2_data  = (rs2_addr == 5'd0) ? '0 : rf[rs2_addr];

  assign dump_busy  = (state == DUMP);
  assign dump_valid = (state == DUMP);
  assign dump_last  = (state == DUMP) &&
                      (dump_idx == 5'(NREG - 1));
  assign dump_data  = ((state == DUMP) && (dump_idx != 5'd0))
                      ? rf[dump_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dump_idx   <= '0;
      starve_cnt <= '0;
      for (int i = 1; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wr_en && (wr_addr != 5'd0)) begin
        rf[wr_addr] <= wr_data;
      end
      unique case (state)
        IDLE: begin
          if (dump_req) begin
            state    <= DUMP;
            dump_idx <= '0;
          end
          if (dbg_fire) begin
            starve_cnt <= '0;
          end else if (dbg_valid && !at_max) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            if (dump_last) begin
              state <= IDLE;
            end else begin
              dump_idx <= dump_idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_arb.sv
// Directed bench for regfile_access_arb: reset, writes, arbitration,
// snapshot dump, backpressure and reset-abort.
module tb_regfile_access_arb;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_addr;
  logic [63:0] dbg_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        dump_req;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [63:0] dump_data;
  logic        dump_last;

  int vectors;
  int miscompares;

  regfile_access_arb #(
    .XLEN(64),
    .NREG(32),
    .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .dump_req  (dump_req),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_idx  (dump_idx),
    .dump_data (dump_data),
    .dump_last (dump_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    wb_valid  = 1'b1;
    wb_addr   = 5'd3;
    wb_data   = 64'h1234;
    dbg_valid = 1'b1;
    dump_req  = 1'b1;
    dump_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (wb_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wb_ready got %b want 0", wb_ready);
    end
    vectors++;
    if (dbg_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_dbg_ready got %b want 0", dbg_ready);
    end
    vectors++;
    if ({dump_valid, dump_busy, dump_last} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_dump_flags got %b want 000",
               {dump_valid, dump_busy, dump_last});
    end
    vectors++;
    if (dump_data !== 64'd0 || dump_idx !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_dump_bus got %h/%0d want 0/0",
               dump_data, dump_idx);
    end
    next_cycle();
    rst       = 1'b0;
    wb_valid  = 1'b0;
    dbg_valid = 1'b0;
    dump_req  = 1'b0;
    rs1_addr  = 5'd5;
    @(negedge clk);
    vectors++;
    if (rs1_data !== 64'd0) begin
      miscompares++;
      $display("FAIL post_rst_x5 got %h want 0", rs1_data);
    end
    vectors++;
    if (wb_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_rst_wb_ready got %b want 1", wb_ready);
    end
    vectors++;
    if (dump_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst_busy got %b want 0", dump_busy);
    end
  endtask

  task automatic test_write_read();
    next_cycle();
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    wb_data  = 64'hDEAD_BEEF_0000_0001;
    rs1_addr = 5'd5;
    @(negedge clk);
    vectors++;
    if (rs1_data !== 64'd0) begin
      miscompares++;
      $display("FAIL no_bypass got %h want 0", rs1_data);
    end
    next_cycle();
    wb_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rs1_data !== 64'hDEAD_BEEF_0000_0001) begin
      miscompares++;
      $display("FAIL wb_x5 got %h want deadbeef00000001",
               rs1_data);
    end
    next_cycle();
    dbg_valid = 1'b1;
    dbg_addr  = 5'd0;
    dbg_data  = 64'h1;
    rs2_addr  = 5'd0;
    @(negedge clk);
    vectors++;
    if (dbg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dbg_x0_ready got %b want 1", dbg_ready);
    end
    next_cycle();
    dbg_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rs2_data !== 64'd0) begin
      miscompares++;
      $display("FAIL x0_read got %h want 0", rs2_data);
    end
  endtask

  task automatic test_starvation();
    logic exp_dbg;
    next_cycle();
    wb_valid  = 1'b1;
    wb_addr   = 5'd1;
    wb_data   = 64'hAAAA;
    dbg_valid = 1'b1;
    dbg_addr  = 5'd2;
    dbg_data  = 64'hBBBB;
    for (int i = 0; i < 10; i++) begin
      exp_dbg = (i == 4) || (i == 9);
      @(negedge clk);
      vectors++;
      if (wb_ready !== !exp_dbg || dbg_ready !== exp_dbg) begin
        miscompares++;
        $display("FAIL starve_c%0d got wb=%b dbg=%b want wb=%b dbg=%b",
                 i, wb_ready, dbg_ready, !exp_dbg, exp_dbg);
      end
      next_cycle();
    end
    wb_valid  = 1'b0;
    dbg_valid = 1'b0;
    rs1_addr  = 5'd1;
    rs2_addr  = 5'd2;
    @(negedge clk);
    vectors++;
    if (rs1_data !== 64'hAAAA || rs2_data !== 64'hBBBB) begin
      miscompares++;
      $display("FAIL starve_data got %h/%h want aaaa/bbbb",
               rs1_data, rs2_data);
    end
  endtask

  task automatic preload();
    next_cycle();
    for (int i = 1; i < 32; i++) begin
      wb_valid = 1'b1;
      wb_addr  = 5'(i);
      wb_data  = 64'(i * 17);
      next_cycle();
    end
    wb_valid = 1'b0;
  endtask

  task automatic test_dump();
    logic [63:0] exp_d;
    preload();
    dump_req   = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (dump_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL dump_pre_busy got %b want 0", dump_busy);
    end
    next_cycle();
    dump_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp_d = 64'(k * 17);
      @(negedge clk);
      vectors++;
      if (dump_valid !== 1'b1 || dump_busy !== 1'b1 ||
          dump_idx !== 5'(k) || dump_data !== exp_d ||
          dump_last !== (k == 31) || wb_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL dump_beat%0d got v=%b b=%b i=%0d d=%h l=%b wr=%b want 1 1 %0d %h %b 0",
                 k, dump_valid, dump_busy, dump_idx, dump_data,
                 dump_last, wb_ready, k, exp_d, k == 31);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (dump_busy !== 1'b0 || wb_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dump_end got busy=%b wr=%b want 0 1",
               dump_busy, wb_ready);
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic [63:0] exp_d;
    next_cycle();
    dump_req = 1'b1;
    next_cycle();
    for (int c = 0; c < 64; c++) begin
      dump_ready = (c % 2) == 1;
      dump_req   = (c == 10);
      k = c / 2;
      exp_d = 64'(k * 17);
      @(negedge clk);
      vectors++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(k) ||
          dump_data !== exp_d) begin
        miscompares++;
        $display("FAIL bp_c%0d got v=%b i=%0d d=%h want 1 %0d %h",
                 c, dump_valid, dump_idx, dump_data, k, exp_d);
      end
      next_cycle();
    end
    dump_req   = 1'b0;
    dump_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (dump_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_idle%0d got busy=%b want 0",
                 c, dump_busy);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d;
    wb_valid   = 1'b1;
    wb_addr    = 5'd7;
    wb_data    = 64'h77;
    dump_req   = 1'b1;
    dump_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (wb_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_cyc_wb_ready got %b want 1", wb_ready);
    end
    next_cycle();
    wb_valid = 1'b0;
    dump_req = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      exp_d = (k == 7) ? 64'h77 : 64'(k * 17);
      @(negedge clk);
      vectors++;
      if (dump_idx !== 5'(k) || dump_data !== exp_d) begin
        miscompares++;
        $display("FAIL b2b_beat%0d got i=%0d d=%h want %0d %h",
                 k, dump_idx, dump_data, k, exp_d);
      end
      if (k < 12) next_cycle();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 ||
        dump_idx !== 5'd0 || dump_data !== 64'd0) begin
      miscompares++;
      $display("FAIL abort got v=%b b=%b i=%0d d=%h want 0 0 0 0",
               dump_valid, dump_busy, dump_idx, dump_data);
    end
    next_cycle();
    rst      = 1'b0;
    rs1_addr = 5'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (dump_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_abort%0d got v=%b want 0",
                 c, dump_valid);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (rs1_data !== 64'd0) begin
      miscompares++;
      $display("FAIL post_abort_x7 got %h want 0", rs1_data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    wb_valid    = 1'b0;
    wb_addr     = 5'd0;
    wb_data     = 64'd0;
    dbg_valid   = 1'b0;
    dbg_addr    = 5'd0;
    dbg_data    = 64'd0;
    rs1_addr    = 5'd0;
    rs2_addr    = 5'd0;
    dump_req    = 1'b0;
    dump_ready  = 1'b0;
    test_reset();
    test_write_read();
    test_starvation();
    test_dump();
    test_backpressure();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
